// File: rtl/aluctrl_md.sv
// ALU control decoder plus iterative radix-2 RV32M/RV64M multiply/divide engine.
// Optional macro ALUCTRL_MD_EARLY_OUT_EN: single-cycle results for zero-operand MUL and |rs1|<|rs2| DIV/REM.
module aluctrl_md #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [6:0]         opcode_i,
    input  logic [2:0]         f3_i,
    input  logic [6:0]         f7_i,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    output logic [ALUOP_W-1:0] aluopr_o,
    output logic               md_sel_o,
    output logic               ready_o,
    output logic               stall_o,
    output logic               done_o,
    output logic [XLEN-1:0]    md_res_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opB;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_f3;
    logic                r_negA;
    logic                r_negB;
    logic                r_done;
    logic                r_ready;
    logic [XLEN-1:0]     r_res;

    logic [3:0]          w_op;
    logic                w_mdSel;
    logic [3:0]          w_baseOp;

    always_comb begin
        case (f3_i)
            3'b000:  w_baseOp = OP_ADD;
            3'b001:  w_baseOp = OP_SLL;
            3'b010:  w_baseOp = OP_SLT;
            3'b011:  w_baseOp = OP_SLTU;
            3'b100:  w_baseOp = OP_XOR;
            3'b101:  w_baseOp = OP_SRL;
            3'b110:  w_baseOp = OP_OR;
            default: w_baseOp = OP_AND;
        endcase
    end

    always_comb begin
        w_op    = OP_ILL;
        w_mdSel = 1'b0;
        case (opcode_i)
            OPC_R: begin
                if (f7_i == 7'b0000001) begin
                    w_mdSel = 1'b1;
                    w_op    = OP_ADD;
                end else if (f7_i == 7'b0000000) begin
                    w_op = w_baseOp;
                end else if (f7_i == 7'b0100000) begin
                    if (f3_i == 3'b000)
                        w_op = OP_SUB;
                    else if (f3_i == 3'b101)
                        w_op = OP_SRA;
                end
            end
            OPC_I: begin
                if (f3_i == 3'b101)
                    w_op = f7_i[5] ? OP_SRA : OP_SRL;
                else
                    w_op = w_baseOp;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: w_op = OP_ADD;
            OPC_BRANCH: begin
                case (f3_i[2:1])
                    2'b00:   w_op = OP_SUB;
                    2'b10:   w_op = OP_SLT;
                    2'b11:   w_op = OP_SLTU;
                    default: w_op = OP_ILL;
                endcase
            end
            default: w_op = OP_ILL;
        endcase
    end

    assign aluopr_o = ALUOP_W'(w_op);
    assign md_sel_o = w_mdSel;

    // Operands are processed as magnitudes; signs are reapplied once the iteration ends.
    logic            w_aSigned, w_bSigned, w_aNeg, w_bNeg;
    logic [XLEN-1:0] w_absA, w_absB;

    assign w_aSigned = (f3_i == 3'b000) || (f3_i == 3'b001) || (f3_i == 3'b010) ||
                       (f3_i == 3'b100) || (f3_i == 3'b110);
    assign w_bSigned = (f3_i == 3'b000) || (f3_i == 3'b001) ||
                       (f3_i == 3'b100) || (f3_i == 3'b110);
    assign w_aNeg    = w_aSigned && rs1_i[XLEN-1];
    assign w_bNeg    = w_bSigned && rs2_i[XLEN-1];
    assign w_absA    = w_aNeg ? -rs1_i : rs1_i;
    assign w_absB    = w_bNeg ? -rs2_i : rs2_i;

    logic            w_div0, w_ovf, w_early, w_fast;
    logic [XLEN-1:0] w_fastRes;

    assign w_div0 = f3_i[2] && (rs2_i == '0);
    assign w_ovf  = f3_i[2] && !f3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
`ifdef ALUCTRL_MD_EARLY_OUT_EN
    assign w_early = (!f3_i[2] && ((rs1_i == '0) || (rs2_i == '0))) ||
                     (f3_i[2] && (w_absA < w_absB));
`else
    assign w_early = 1'b0;
`endif
    assign w_fast = w_div0 || w_ovf || w_early;

    always_comb begin
        w_fastRes = '0;
        if (w_div0)
            w_fastRes = f3_i[1] ? rs1_i : '1;
        else if (w_ovf)
            w_fastRes = f3_i[1] ? '0 : rs1_i;
        else if (w_early && f3_i[2] && f3_i[1])
            w_fastRes = rs1_i;
    end

    // Multiply: {hi,lo} shift-add with multiplier in lo. Divide: restoring, remainder in hi, quotient shifts into lo.
    logic [XLEN:0]     w_mulSum;
    logic [XLEN:0]     w_remTmp;
    logic [XLEN-1:0]   w_remSub;
    logic              w_geq;
    logic [2*XLEN-1:0] w_mulNext, w_divNext, w_accNext, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_finalRes;

    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opB} : '0);
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};
    assign w_remTmp  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_geq     = w_remTmp >= {1'b0, r_opB};
    assign w_remSub  = w_remTmp[XLEN-1:0] - r_opB;
    assign w_divNext = {(w_geq ? w_remSub : w_remTmp[XLEN-1:0]), r_acc[XLEN-2:0], w_geq};
    assign w_accNext = r_f3[2] ? w_divNext : w_mulNext;

    assign w_prod = (r_negA ^ r_negB) ? -w_accNext : w_accNext;
    assign w_quo  = w_accNext[XLEN-1:0];
    assign w_rem  = w_accNext[2*XLEN-1:XLEN];

    always_comb begin
        case (r_f3)
            3'b000:         w_finalRes = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_finalRes = (r_negA ^ r_negB) ? -w_quo : w_quo;
            3'b110, 3'b111: w_finalRes = r_negA ? -w_rem : w_rem;
            default:        w_finalRes = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_opB   <= '0;
            r_cnt   <= '0;
            r_f3    <= '0;
            r_negA  <= 1'b0;
            r_negB  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_res   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (valid_i && w_mdSel) begin
                        r_f3    <= f3_i;
                        r_negA  <= w_aNeg;
                        r_negB  <= w_bNeg;
                        r_ready <= 1'b0;
                        if (w_fast) begin
                            r_res   <= w_fastRes;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, (f3_i[2] ? w_absA : w_absB)};
                            r_opB   <= f3_i[2] ? w_absB : w_absA;
                            r_cnt   <= CNT_W'(XLEN);
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= w_finalRes;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The issuing cycle already stalls; the DONE cycle lets the instruction retire.
    always_comb begin
        case (r_state)
            S_IDLE:  stall_o = valid_i && w_mdSel;
            S_BUSY:  stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

    assign ready_o  = r_ready;
    assign done_o   = r_done;
    assign md_res_o = r_res;

endmodule

// File: tb/tb_aluctrl_md.sv
// Directed self-checking bench for aluctrl_md: decode table, M-ext results, latencies, flush and reset.
// A second instance with XLEN=64 covers the wide datapath.
module tb_aluctrl_md;

    logic        clk = 1'b0;
    logic        rstN;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        valid;
    logic        valid64;
    logic        flush;
    logic [31:0] rs1, rs2;
    logic [63:0] rs1w, rs2w;

    logic [3:0]  aluOp, aluOp64;
    logic        mdSel, mdSel64;
    logic        ready, ready64;
    logic        stall, stall64;
    logic        done, done64;
    logic [31:0] mdRes;
    logic [63:0] mdRes64;

    int nCompared   = 0;
    int nMismatched = 0;

`ifdef ALUCTRL_MD_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    always #5 clk = ~clk;

    aluctrl_md #(.XLEN(32), .ALUOP_W(4)) dut (
        .clk_i(clk), .rst_ni(rstN), .opcode_i(opcode), .f3_i(funct3), .f7_i(funct7),
        .valid_i(valid), .flush_i(flush), .rs1_i(rs1), .rs2_i(rs2),
        .aluopr_o(aluOp), .md_sel_o(mdSel), .ready_o(ready), .stall_o(stall),
        .done_o(done), .md_res_o(mdRes)
    );

    aluctrl_md #(.XLEN(64), .ALUOP_W(4)) dut64 (
        .clk_i(clk), .rst_ni(rstN), .opcode_i(opcode), .f3_i(funct3), .f7_i(funct7),
        .valid_i(valid64), .flush_i(flush), .rs1_i(rs1w), .rs2_i(rs2w),
        .aluopr_o(aluOp64), .md_sel_o(mdSel64), .ready_o(ready64), .stall_o(stall64),
        .done_o(done64), .md_res_o(mdRes64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
    endtask

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        opcode = 7'b0110011;
        funct7 = 7'b0000001;
        funct3 = fn;
        rs1    = a;
        rs2    = b;
        valid  = 1'b1;
        step();
        valid  = 1'b0;
        opcode = 7'b0010011;
        funct7 = 7'b0000000;
    endtask

    // Latency counts edges from the accepting edge to the first cycle showing done.
    task automatic runMd(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        waitReady();
        issue(fn, a, b);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        res = mdRes;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        step();
        step();
        nCompared++;
        if ({ready, done, stall, mdRes} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: got rdy/done/stall/res %b%b%b %h expected 100 00000000",
                     ready, done, stall, mdRes);
        end
        nCompared++;
        if ({ready64, done64, mdRes64} !== {1'b1, 1'b0, 64'h0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_state64: got rdy/done %b%b res %h expected 10 0", ready64, done64, mdRes64);
        end
        rstN = 1'b1;
        step();
    endtask

    task automatic test_decode();
        logic [21:0] vecs [15] = '{
            {7'b0110011, 3'b101, 7'b0100000, 4'b1011, 1'b0},
            {7'b0010011, 3'b101, 7'b0000000, 4'b1010, 1'b0},
            {7'b1100011, 3'b110, 7'b0000000, 4'b0110, 1'b0},
            {7'b1111111, 3'b000, 7'b0000000, 4'b1111, 1'b0},
            {7'b0000011, 3'b010, 7'b0000000, 4'b0000, 1'b0},
            {7'b0110011, 3'b001, 7'b0100000, 4'b1111, 1'b0},
            {7'b0110011, 3'b000, 7'b0000000, 4'b0000, 1'b0},
            {7'b0110011, 3'b100, 7'b0000001, 4'b0000, 1'b1},
            {7'b0110011, 3'b010, 7'b0000000, 4'b0101, 1'b0},
            {7'b1100011, 3'b010, 7'b0000000, 4'b1111, 1'b0},
            {7'b0010011, 3'b101, 7'b0100000, 4'b1011, 1'b0},
            {7'b0100011, 3'b000, 7'b0000000, 4'b0000, 1'b0},
            {7'b0110011, 3'b111, 7'b0000000, 4'b0001, 1'b0},
            {7'b1100011, 3'b001, 7'b0000000, 4'b0100, 1'b0},
            {7'b0010011, 3'b011, 7'b0100000, 4'b0110, 1'b0}
        };
        logic [3:0] expOp;
        logic       expSel;
        for (int i = 0; i < 15; i++) begin
            opcode = vecs[i][21:15];
            funct3 = vecs[i][14:12];
            funct7 = vecs[i][11:5];
            expOp  = vecs[i][4:1];
            expSel = vecs[i][0];
            #1;
            nCompared++;
            if ({aluOp, mdSel} !== {expOp, expSel}) begin
                nMismatched++;
                $display("[TB] FAIL decode_%0d: got op %b sel %b expected op %b sel %b",
                         i, aluOp, mdSel, expOp, expSel);
            end
        end
        opcode = 7'b0010011;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        step();
    endtask

    task automatic test_mul();
        int cycles;
        int stallBad = 0;
        waitReady();
        opcode = 7'b0110011;
        funct7 = 7'b0000001;
        funct3 = 3'b000;
        rs1    = 32'd7;
        rs2    = 32'hFFFFFFFD;
        valid  = 1'b1;
        #1;
        nCompared++;
        if (stall !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL mul_issue_stall: got %b expected 1", stall);
        end
        step();
        valid  = 1'b0;
        opcode = 7'b0010011;
        funct7 = 7'b0000000;
        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            if (stall !== 1'b1) stallBad++;
            step();
            cycles++;
        end
        nCompared++;
        if (cycles !== 33) begin
            nMismatched++;
            $display("[TB] FAIL mul_latency: got %0d expected 33", cycles);
        end
        nCompared++;
        if (stallBad !== 0) begin
            nMismatched++;
            $display("[TB] FAIL mul_busy_stall: got %0d low cycles expected 0", stallBad);
        end
        nCompared++;
        if (mdRes !== 32'hFFFFFFEB) begin
            nMismatched++;
            $display("[TB] FAIL mul_result: got %h expected ffffffeb", mdRes);
        end
        nCompared++;
        if ({stall, ready} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL mul_done_stall_ready: got %b%b expected 00", stall, ready);
        end
        step();
        nCompared++;
        if ({done, ready, mdRes} !== {1'b0, 1'b1, 32'hFFFFFFEB}) begin
            nMismatched++;
            $display("[TB] FAIL mul_after_done: got done %b rdy %b res %h expected 0 1 ffffffeb",
                     done, ready, mdRes);
        end
    endtask

    task automatic test_mulh();
        logic [31:0] res;
        int          lat;
        runMd(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFE || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL mulhu: got %h lat %0d expected fffffffe lat 33", res, lat);
        end
        runMd(3'b001, 32'h80000000, 32'h80000000, res, lat);
        nCompared++;
        if (res !== 32'h40000000 || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL mulh: got %h lat %0d expected 40000000 lat 33", res, lat);
        end
        runMd(3'b010, 32'hFFFFFFFF, 32'd2, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFF || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL mulhsu: got %h lat %0d expected ffffffff lat 33", res, lat);
        end
    endtask

    task automatic test_div();
        logic [31:0] res;
        int          lat;
        runMd(3'b100, 32'hFFFFFFF9, 32'd2, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFD || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL div_neg: got %h lat %0d expected fffffffd lat 33", res, lat);
        end
        runMd(3'b110, 32'hFFFFFFF9, 32'd2, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFF || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL rem_neg: got %h lat %0d expected ffffffff lat 33", res, lat);
        end
        runMd(3'b100, 32'd7, 32'hFFFFFFFD, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFE) begin
            nMismatched++;
            $display("[TB] FAIL div_negdivisor: got %h expected fffffffe", res);
        end
        runMd(3'b110, 32'd7, 32'hFFFFFFFD, res, lat);
        nCompared++;
        if (res !== 32'h00000001) begin
            nMismatched++;
            $display("[TB] FAIL rem_negdivisor: got %h expected 00000001", res);
        end
    endtask

    task automatic test_div_corner();
        logic [31:0] res;
        int          lat;
        runMd(3'b101, 32'd7, 32'd0, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFF || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL divu_by_zero: got %h lat %0d expected ffffffff lat 1", res, lat);
        end
        runMd(3'b111, 32'd7, 32'd0, res, lat);
        nCompared++;
        if (res !== 32'd7 || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL remu_by_zero: got %h lat %0d expected 00000007 lat 1", res, lat);
        end
        runMd(3'b100, 32'h80000000, 32'hFFFFFFFF, res, lat);
        nCompared++;
        if (res !== 32'h80000000 || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL div_overflow: got %h lat %0d expected 80000000 lat 1", res, lat);
        end
        runMd(3'b110, 32'h80000000, 32'hFFFFFFFF, res, lat);
        nCompared++;
        if (res !== 32'h0 || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL rem_overflow: got %h lat %0d expected 00000000 lat 1", res, lat);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prevRes;
        logic [31:0] res;
        int          lat;
        int          pulses = 0;
        waitReady();
        prevRes = mdRes;
        issue(3'b101, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        nCompared++;
        if ({ready, stall, done} !== 3'b100) begin
            nMismatched++;
            $display("[TB] FAIL flush_idle: got rdy/stall/done %b%b%b expected 100", ready, stall, done);
        end
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        nCompared++;
        if (pulses !== 0 || mdRes !== prevRes) begin
            nMismatched++;
            $display("[TB] FAIL flush_no_done: got %0d pulses res %h expected 0 pulses res %h",
                     pulses, mdRes, prevRes);
        end
        runMd(3'b101, 32'd100, 32'd7, res, lat);
        nCompared++;
        if (res !== 32'd14 || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL divu_after_flush: got %h lat %0d expected 0000000e lat 33", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        waitReady();
        issue(3'b000, 32'd5, 32'd6);
        for (int i = 0; i < 5; i++) step();
        nCompared++;
        if ({stall, ready} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL busy_before_reset: got stall/rdy %b%b expected 10", stall, ready);
        end
        rstN = 1'b0;
        flush = 1'b1;
        step();
        rstN = 1'b1;
        flush = 1'b0;
        nCompared++;
        if ({ready, done, stall, mdRes} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_busy: got rdy/done/stall %b%b%b res %h expected 100 00000000",
                     ready, done, stall, mdRes);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        runMd(3'b000, 32'd12, 32'd12, res, lat);
        nCompared++;
        if (res !== 32'd144 || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL b2b_mul: got %h lat %0d expected 00000090 lat 33", res, lat);
        end
        runMd(3'b101, 32'd144, 32'd12, res, lat);
        nCompared++;
        if (res !== 32'd12 || lat !== 33) begin
            nMismatched++;
            $display("[TB] FAIL b2b_divu: got %h lat %0d expected 0000000c lat 33", res, lat);
        end
        step();
        nCompared++;
        if ({done, mdRes} !== {1'b0, 32'd12}) begin
            nMismatched++;
            $display("[TB] FAIL b2b_hold: got done %b res %h expected 0 0000000c", done, mdRes);
        end
    endtask

    task automatic test_xlen64();
        int lat;
        int guard = 0;
        while (ready64 !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        opcode  = 7'b0110011;
        funct7  = 7'b0000001;
        funct3  = 3'b000;
        rs1w    = 64'd3;
        rs2w    = 64'd5;
        valid64 = 1'b1;
        step();
        valid64 = 1'b0;
        opcode  = 7'b0010011;
        funct7  = 7'b0000000;
        lat = 1;
        while (done64 !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        nCompared++;
        if (mdRes64 !== 64'd15 || lat !== 65) begin
            nMismatched++;
            $display("[TB] FAIL mul64: got %h lat %0d expected 000000000000000f lat 65", mdRes64, lat);
        end
    endtask

    task automatic test_early_out();
        logic [31:0] res;
        int          lat;
        runMd(3'b000, 32'd0, 32'd5, res, lat);
        nCompared++;
        if (res !== 32'h0 || lat !== EARLY_LAT) begin
            nMismatched++;
            $display("[TB] FAIL mul_zero: got %h lat %0d expected 00000000 lat %0d", res, lat, EARLY_LAT);
        end
        runMd(3'b101, 32'd3, 32'd10, res, lat);
        nCompared++;
        if (res !== 32'h0 || lat !== EARLY_LAT) begin
            nMismatched++;
            $display("[TB] FAIL divu_small: got %h lat %0d expected 00000000 lat %0d", res, lat, EARLY_LAT);
        end
        runMd(3'b110, 32'hFFFFFFFD, 32'd10, res, lat);
        nCompared++;
        if (res !== 32'hFFFFFFFD || lat !== EARLY_LAT) begin
            nMismatched++;
            $display("[TB] FAIL rem_small: got %h lat %0d expected fffffffd lat %0d", res, lat, EARLY_LAT);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN    = 1'b0;
        opcode  = 7'b0010011;
        funct3  = 3'b000;
        funct7  = 7'b0000000;
        valid   = 1'b0;
        valid64 = 1'b0;
        flush   = 1'b0;
        rs1     = '0;
        rs2     = '0;
        rs1w    = '0;
        rs2w    = '0;
        $display("[TB] starting aluctrl_md bench");
        test_reset();
        test_decode();
        test_mul();
        test_mulh();
        test_div();
        test_div_corner();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_xlen64();
        test_early_out();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/aluctrl_md.md
Name: aluctrl_md

Overview:
- Parametrised successor ALU control block for the single-cycle RISC-V core.
- Decodes opcode/funct3/full funct7 into the 4-bit ALU operation code (combinational, as before).
- Adds a sequential RV32M/RV64M multiply/divide engine: iterative radix-2 multi-cycle unit with start/done handshake.
- Asserts a stall to the PC/regfile while a M-extension op is in flight.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- ALUOP_W, 4, width of aluopr_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous reset, active-low.
- opcode_i  in  7  instruction opcode field.
- f3_i  in  3  funct3.
- f7_i  in  7  funct7 (full field; bit5 selects SUB/SRA, 0000001 selects M-ext).
- valid_i  in  1  instruction valid this cycle.
- flush_i  in  1  abort any in-flight M op.
- rs1_i  in  XLEN  operand A.
- rs2_i  in  XLEN  operand B.
- aluopr_o  out  ALUOP_W  ALU op code (combinational).
- md_sel_o  out  1  writeback mux selects md_res_o (combinational: current instr is M-ext).
- ready_o  out  1  engine idle, can accept.
- stall_o  out  1  hold PC/regfile write.
- done_o  out  1  one-cycle pulse, md_res_o valid.
- md_res_o  out  XLEN  M-ext result, held until next accept.

Behaviour:
- ALU op encoding: 0000 ADD, 0001 AND, 0010 OR, 0011 XOR, 0100 SUB, 0101 SLT, 0110 SLTU, 1000 SLL, 1010 SRL, 1011 SRA, 1111 illegal/default.
- R-type (0110011), f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- R-type, f7=0100000: f3 000 SUB, 101 SRA; any other f3 -> 1111.
- I-type (0010011): same as R-type with f7 ignored, except f3=101 uses f7[5] (SRAI/SRLI).
- Load 0000011, store 0100011, JALR 1100111, AUIPC 0010111 -> ADD.
- Branch 1100011: f3 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 -> 1111.
- Any other opcode -> 1111.
- M-ext: opcode 0110011 and f7=0000001 -> md_sel_o=1, aluopr_o=0000.
- FSM states: IDLE, BUSY, DONE.
  - Reset: state IDLE, md_res_o=0, done_o=0, stall_o=0, ready_o=1, counter=0.
  - IDLE -> BUSY on valid_i & md_sel_o: latch f3, operand magnitudes, result signs; counter=XLEN.
  - In IDLE, stall_o = valid_i & md_sel_o (combinational), so the issuing cycle stalls.
  - BUSY: one shift-add (mul) or shift-subtract restoring step (div) per cycle; counter decrements; stall_o=1, ready_o=0. Counter reaching 1 -> DONE.
  - DONE: done_o=1, md_res_o registered with sign fix-up applied, stall_o=0 (instruction retires this cycle), ready_o=0. Unconditionally -> IDLE next cycle.
- Latency: accept at edge N; done_o high in cycle N+XLEN+1.
- Accumulator is 2*XLEN wide for mul. MUL returns low half; MULH/MULHSU/MULHU return the high half with signed/signed, signed/unsigned, unsigned/unsigned operand treatment.
- DIV/REM signed, DIVU/REMU unsigned. Remainder sign follows dividend.
- Divide by zero: quotient all-ones, remainder = rs1. Skips BUSY: IDLE -> DONE, latency 1.
- Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1, DIV/REM): quotient = rs1, remainder = 0, latency 1.
- valid_i while not IDLE is ignored (core is stalled; must not occur).
- flush_i: any state -> IDLE next edge. done_o not pulsed; md_res_o keeps its old value.
- rst_ni low mid-operation: full reset values next edge. rst_ni has priority over flush_i.

Optional Feature:
- Macro: ALUCTRL_MD_EARLY_OUT_EN.
- Defined: MUL* with either operand zero -> IDLE -> DONE with result 0, latency 1. DIV*/REM* with |rs1| < |rs2| (compared unsigned on magnitudes) -> latency 1, quotient 0, remainder = rs1.
- Undefined: these cases take the full XLEN+1 latency with identical results.

Test Plan:
- Decode sweep: R f7=0100000 f3=101 -> aluopr_o=1011; I f3=101 f7[5]=0 -> 1010; branch f3=110 -> 0110; opcode 1111111 -> 1111; load -> 0000.
- MUL XLEN=32: rs1=7, rs2=-3 -> done_o at accept+33 cycles, md_res_o=0xFFFFFFEB; stall_o high from the issuing cycle through BUSY, low in the DONE cycle.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF with latency 1. DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0.
- flush_i asserted at accept+10 -> IDLE next cycle, no done_o pulse, ready_o=1. Next DIVU 100/7 -> 14 correctly.
- rst_ni low 1 cycle mid-BUSY -> all outputs at reset values. With XLEN=64, MUL 3*5 -> 15 at accept+65 cycles; with ALUCTRL_MD_EARLY_OUT_EN, MUL 0*5 -> 0 at accept+1.
